// File: rtl/product_bcd_converter.sv
// product_bcd_converter: serial double-dabble conversion of a signed product to sign + BCD magnitude.
module product_bcd_converter #(
  parameter int W_IN     = 9,
  parameter int N_DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [W_IN-1:0]       i_fu,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_neg,
  output logic [4*N_DIGITS-1:0] o_bcd
);
  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(W_IN + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t          state;
  logic [BW-1:0]   bcd_w;
  logic [BW-1:0]   bcd_adj;
  logic [W_IN-1:0] mag;
  logic            neg;
  logic [CW-1:0]   cnt;
  always_comb begin
    bcd_adj = bcd_w;
    for (int d = 0; d < N_DIGITS; d++)
      bcd_adj[4*d +: 4] = (bcd_w[4*d +: 4] >= 4'd5) ? bcd_w[4*d +: 4] + 4'd3 : bcd_w[4*d +: 4];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      bcd_w  <= '0;
      mag    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_neg  <= 1'b0;
      o_bcd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            neg    <= i_fu[W_IN-1];
            mag    <= i_fu[W_IN-1] ? -i_fu : i_fu;
            bcd_w  <= '0;
            cnt    <= CW'(W_IN);
            o_busy <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_w, mag} <= {bcd_adj, mag} << 1;
          cnt          <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          o_bcd  <= bcd_w;
          o_neg  <= neg;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_product_bcd_converter.sv
// tb_product_bcd_converter: directed checks of the signed product to BCD converter.
module tb_product_bcd_converter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  fu = '0;
  logic        busy, done, neg;
  logic [11:0] bcd;
  int          total = 0;
  int          bad = 0;
  int          c;
  int          n_done;
  product_bcd_converter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_fu(fu),
    .o_busy(busy), .o_done(done), .o_neg(neg), .o_bcd(bcd)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 30);
    check("done_seen", {31'd0, done}, 32'd1);
  endtask
  task automatic convert(input string tag, input int v, input logic [11:0] eb, input logic en);
    int cyc;
    @(negedge clk);
    check({tag, "_done_low_before"}, {31'd0, done}, 32'd0);
    start = 1'b1;
    fu = 9'(v);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd10);
    check({tag, "_bcd"}, {20'd0, bcd}, {20'd0, eb});
    check({tag, "_neg"}, {31'd0, neg}, {31'd0, en});
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    start = 1'b1;
    fu = 9'(-225);
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_neg", {31'd0, neg}, 32'd0);
      check("rst_bcd", {20'd0, bcd}, 32'h000);
    end
    start = 1'b0;
    rst_n = 1'b1;
    convert("zero", 0, 12'h000, 1'b0);
    convert("three", 3, 12'h003, 1'b0);
    convert("m225", -225, 12'h225, 1'b1);
    convert("p225", 225, 12'h225, 1'b0);
    convert("m256", -256, 12'h256, 1'b1);
    convert("p255", 255, 12'h255, 1'b0);
    convert("m1", -1, 12'h001, 1'b1);
    // start ignored while busy; previous result must persist until the new done
    @(negedge clk);
    start = 1'b1;
    fu = 9'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    fu = 9'(-7);
    @(negedge clk);
    start = 1'b0;
    check("busy_hold_bcd", {20'd0, bcd}, 32'h001);
    check("busy_hold_neg", {31'd0, neg}, 32'd1);
    check("busy_hold_busy", {31'd0, busy}, 32'd1);
    wait_done(c);
    check("busy_latency", 32'(c), 32'd6);
    check("busy_bcd", {20'd0, bcd}, 32'h100);
    check("busy_neg", {31'd0, neg}, 32'd0);
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("busy_no_extra_done", 32'(n_done), 32'd0);
    // back-to-back with start held high
    start = 1'b1;
    fu = 9'd17;
    @(negedge clk);
    fu = 9'(-42);
    wait_done(c);
    check("b2b_first_latency", 32'(c), 32'd10);
    check("b2b_first_bcd", {20'd0, bcd}, 32'h017);
    check("b2b_first_neg", {31'd0, neg}, 32'd0);
    wait_done(c);
    start = 1'b0;
    check("b2b_gap", 32'(c), 32'd11);
    check("b2b_second_bcd", {20'd0, bcd}, 32'h042);
    check("b2b_second_neg", {31'd0, neg}, 32'd1);
    @(negedge clk);
    check("b2b_done_single", {31'd0, done}, 32'd0);
    // abort mid-conversion
    repeat (15) @(negedge clk);
    start = 1'b1;
    fu = 9'd123;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_neg", {31'd0, neg}, 32'd0);
    check("abort_bcd", {20'd0, bcd}, 32'h000);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_bcd_after", {20'd0, bcd}, 32'h000);
    convert("n99", 99, 12'h099, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
